from8bit: RTL and testbench
===========================

Name: from8bit

Overview:
- Byte-to-word deserializer: the receive-side counterpart of the 8-bit serializer.
- Accepts an 8-bit byte stream and reassembles 8-, 16- or 32-bit words, selected by `dataS` with the same encoding the serializer uses.
- Runs entirely in a single clock domain, with no derived clocks. The assembled word is presented with a one-cycle `validOut` strobe.
- Sits between the 8-bit link and the wide-datapath consumer.

Parameters:
- MSB_FIRST, 1: 1 = first byte received is the most-significant byte of the word; 0 = first byte is the least-significant byte.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- enb  input  1  block enable; 0 freezes all state.
- validIn  input  1  dataIn carries a byte this cycle.
- dataIn  input  8  incoming byte.
- dataS  input  2  word size: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- dataOut  output  32  assembled word, zero-extended to 32 bits.
- widthOut  output  2  dataS value of the word currently on dataOut.
- validOut  output  1  one-cycle strobe: new word on dataOut.
- busy  output  1  partial word in progress (byte count != 0).

Behaviour:
- Reset (rst=0 at posedge):
  - byte count, shift register, dataOut, widthOut, validOut and busy all go to 0.
  - rst=0 overrides enb and validIn; a partial word is discarded and no strobe is produced.
- Accepted byte: enb=1 and validIn=1 at a posedge.
- N (bytes per word): 1 for 00, 2 for 01, 4 for 10.
- Width latching:
  - wordWidth is latched from dataS on the first byte of each word (count=0).
  - Every later byte compares dataS against wordWidth.
- Byte placement:
  - MSB_FIRST=1: shift <= {shift[23:0], dataIn}.
  - MSB_FIRST=0: byte k (0-based) is written to bits [8k+7:8k].
- Word completion:
  - The accepted byte that brings count to N completes the word.
  - On that same edge, dataOut <= assembled word, with bits above 8N forced to 0.
  - On that same edge, widthOut <= wordWidth, validOut <= 1 and count <= 0.
- Latency: validOut rises on the posedge that samples the last byte, i.e. one cycle after that byte is presented.
- validOut is high for exactly one cycle per completed word and is 0 in every other cycle.
- dataOut/widthOut hold their values until the next completion.
- Back-to-back words: a new word's first byte may be accepted in the cycle immediately after completion, with no bubble. In 8-bit mode validOut stays high every cycle while bytes stream.
- validIn=0 with enb=1: no state change except validOut <= 0. Gaps between bytes of one word are allowed.
- enb=0:
  - count, shift, dataOut and widthOut are held.
  - validOut <= 0.
  - The partial word resumes when enb returns to 1.
- Width change mid-word:
  - Condition: an accepted byte with count!=0 and dataS != wordWidth.
  - The partial word is discarded with no strobe.
  - The current byte becomes byte 0 of a new word under the new dataS. With dataS=00 it completes immediately.
- dataS=11: the byte is dropped, count <= 0, any partial word is discarded, and no strobe is produced.
- busy = (count != 0), registered.

Optional Feature:
- Macro: FROM8BIT_ERR_EN.
- Defined:
  - Adds output errOut (1 bit).
  - errOut pulses high for one cycle on the edge that discards a partial word, due to either a width change mid-word or dataS=11 with count!=0.
  - errOut resets to 0.
- Undefined: port errOut is absent. Discard behaviour is identical, just silent.

Test Plan:
- Reset then 8-bit stream: rst=0 for 4 cycles, then rst=1, dataS=00, bytes ff,00,f0,0f,9a,6d on consecutive cycles. Required: validOut high 6 consecutive cycles; dataOut = 000000ff, 00000000, 000000f0, 0000000f, 0000009a, 0000006d; widthOut=00.
- 16-bit, MSB_FIRST=1, dataS=01: bytes ad,43,54,3f. Required: after the 2nd byte, dataOut=0000ad43 with a single validOut; after the 4th, 0000543f; busy=1 only between the 1st and 2nd byte of each pair.
- 32-bit with gaps, dataS=10: bytes 95,fd,ad,43, with validIn=0 for 3 cycles between fd and ad. Required: exactly one strobe, dataOut=95fdad43, widthOut=10. Repeat with MSB_FIRST=0: dataOut=43adfd95.
- enb hold, dataS=10: bytes 03,78, then enb=0 for 5 cycles, then enb=1 with bytes fd,ae. Required: no strobe while enb=0; then dataOut=0378fdae.
- Width switch mid-word, dataS=10: bytes 11,22, then dataS=01 with bytes 33,44. Required: no strobe for 11,22; dataOut=00003344, widthOut=01; errOut pulse on byte 33 when FROM8BIT_ERR_EN is defined.
- Reset mid-word, dataS=01: byte aa, then rst=0 for one cycle, then bytes bb,cc. Required: no strobe during or after the reset cycle until dataOut=0000bbcc; all outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/from8bit.sv
// -----------------------------------------------------------------------------
// from8bit -- byte-to-word deserializer
//
// Reassembles 8-, 16- or 32-bit words from an 8-bit byte stream. It is the
// receive-side counterpart of the 8-bit serializer and uses the same dataS
// encoding. A completed word is presented on dataOut together with a
// one-cycle validOut strobe.
//
// Parameters:
//   MSB_FIRST  1: first byte received is the most-significant byte of the word
//              0: first byte received is the least-significant byte
//
// Optional build macro:
//   FROM8BIT_ERR_EN  adds output errOut, a one-cycle pulse on every edge that
//                    discards a partial word (width change mid-word, or
//                    dataS=11 while a word is in progress).
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous reset, active low
//   enb       in   1   block enable; 0 freezes all state (validOut drops)
//   validIn   in   1   dataIn carries a byte this cycle
//   dataIn    in   8   incoming byte
//   dataS     in   2   word size: 00=8b, 01=16b, 10=32b, 11=reserved (dropped)
//   dataOut   out  32  assembled word, zero-extended
//   widthOut  out  2   dataS value of the word on dataOut
//   validOut  out  1   one-cycle strobe: new word on dataOut
//   busy      out  1   partial word in progress
//   errOut    out  1   (FROM8BIT_ERR_EN only) partial word discarded
// -----------------------------------------------------------------------------
module from8bit #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        validIn,
    input  logic [7:0]  dataIn,
    input  logic [1:0]  dataS,
    output logic [31:0] dataOut,
    output logic [1:0]  widthOut,
    output logic        validOut,
    output logic        busy
`ifdef FROM8BIT_ERR_EN
    ,
    output logic        errOut
`endif
);

    logic [1:0]  count_q, count_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  word_width_q, word_width_d;
    logic [31:0] data_out_q, data_out_d;
    logic [1:0]  width_out_q, width_out_d;
    logic        valid_out_q, valid_out_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        reserved;
    logic        mismatch;
    logic        start;
    logic [1:0]  eff_width;
    logic [1:0]  byte_idx;
    logic [1:0]  last_idx;
    logic [2:0]  n_bytes;
    logic [31:0] base_word;
    logic [31:0] assembled;
    logic [31:0] out_mask;
    logic        complete;

    assign accept   = enb && validIn;
    assign reserved = (dataS == 2'b11);
    // A byte arriving mid-word with a different size abandons the old word.
    assign mismatch = (count_q != 2'd0) && (dataS != word_width_q);
    // This byte opens a fresh word: either nothing pending or the pending
    // word is being abandoned.
    assign start     = (count_q == 2'd0) || mismatch;
    assign eff_width = start ? dataS : word_width_q;
    assign byte_idx  = start ? 2'd0 : count_q;
    // Starting from zero keeps stale bytes of an abandoned word out of the
    // new one, whichever byte order is in use.
    assign base_word = start ? 32'd0 : shift_q;

    always_comb begin
        last_idx = 2'd3;
        case (eff_width)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign n_bytes  = {1'b0, last_idx} + 3'd1;
    assign complete = (byte_idx == last_idx);

    // Byte lanes beyond the word size are forced to zero on output.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_mask
            assign out_mask[8*gi +: 8] = (3'(gi) < n_bytes) ? 8'hff : 8'h00;
        end

        if (MSB_FIRST != 0) begin : gen_msb
            assign assembled = (base_word << 8) | {24'd0, dataIn};
        end else begin : gen_lsb
            for (gi = 0; gi < 4; gi++) begin : gen_lane
                assign assembled[8*gi +: 8] =
                    (byte_idx == 2'(gi)) ? dataIn : base_word[8*gi +: 8];
            end
        end
    endgenerate

    always_comb begin
        count_d      = count_q;
        shift_d      = shift_q;
        word_width_d = word_width_q;
        data_out_d   = data_out_q;
        width_out_d  = width_out_q;
        valid_out_d  = 1'b0;

        if (accept) begin
            if (reserved) begin
                // Reserved size: drop the byte and forget any partial word.
                count_d = 2'd0;
            end else begin
                shift_d      = assembled;
                word_width_d = eff_width;
                if (complete) begin
                    data_out_d  = assembled & out_mask;
                    width_out_d = eff_width;
                    valid_out_d = 1'b1;
                    count_d     = 2'd0;
                end else begin
                    count_d = byte_idx + 2'd1;
                end
            end
        end

        busy_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q      <= 2'd0;
            shift_q      <= 32'd0;
            word_width_q <= 2'd0;
            data_out_q   <= 32'd0;
            width_out_q  <= 2'd0;
            valid_out_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else if (enb) begin
            count_q      <= count_d;
            shift_q      <= shift_d;
            word_width_q <= word_width_d;
            data_out_q   <= data_out_d;
            width_out_q  <= width_out_d;
            valid_out_q  <= valid_out_d;
            busy_q       <= busy_d;
        end else begin
            valid_out_q  <= 1'b0;
        end
    end

    assign dataOut  = data_out_q;
    assign widthOut = width_out_q;
    assign validOut = valid_out_q;
    assign busy     = busy_q;

`ifdef FROM8BIT_ERR_EN
    logic err_q;
    logic discard;

    // Any accepted byte that finds a partial word under a different size
    // (dataS=11 always differs, as wordWidth never holds 11) throws it away.
    assign discard = accept && (count_q != 2'd0) && (reserved || mismatch);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= discard;
        end
    end

    assign errOut = err_q;
`endif

endmodule

// File: tb/tb_from8bit.sv
// -----------------------------------------------------------------------------
// tb_from8bit -- self-checking bench for from8bit.
// Two instances share the stimulus: one MSB-first, one LSB-first. A table of
// per-cycle records gives inputs and the outputs expected after that edge;
// completed words are also pushed to a scoreboard queue per instance and
// popped when the instance strobes validOut.
// -----------------------------------------------------------------------------
module tb_from8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        validIn;
    logic [7:0]  dataIn;
    logic [1:0]  dataS;

    logic [31:0] data_m, data_l;
    logic [1:0]  width_m, width_l;
    logic        valid_m, valid_l;
    logic        busy_m, busy_l;
`ifdef FROM8BIT_ERR_EN
    logic        err_m, err_l;
`endif

    always #5 clk = ~clk;

    from8bit #(.MSB_FIRST(1)) dut_m (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .validIn  (validIn),
        .dataIn   (dataIn),
        .dataS    (dataS),
        .dataOut  (data_m),
        .widthOut (width_m),
        .validOut (valid_m),
        .busy     (busy_m)
`ifdef FROM8BIT_ERR_EN
        ,
        .errOut   (err_m)
`endif
    );

    from8bit #(.MSB_FIRST(0)) dut_l (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .validIn  (validIn),
        .dataIn   (dataIn),
        .dataS    (dataS),
        .dataOut  (data_l),
        .widthOut (width_l),
        .validOut (valid_l),
        .busy     (busy_l)
`ifdef FROM8BIT_ERR_EN
        ,
        .errOut   (err_l)
`endif
    );

    typedef struct {
        logic        r;
        logic        e;
        logic        v;
        logic [1:0]  ds;
        logic [7:0]  din;
        logic        ev;
        logic [31:0] dm;
        logic [31:0] dl;
        logic [1:0]  w;
        logic        b;
        logic        er;
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] sb_m[$];
    logic [33:0] sb_l[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic v, input logic [1:0] ds,
                       input logic [7:0] din, input logic ev, input logic [31:0] dm,
                       input logic [31:0] dl, input logic [1:0] w, input logic b, input logic er);
        vec_t x;
        x.r = r; x.e = e; x.v = v; x.ds = ds; x.din = din;
        x.ev = ev; x.dm = dm; x.dl = dl; x.w = w; x.b = b; x.er = er;
        vecs.push_back(x);
    endtask

    // Pop one scoreboard entry per strobe and compare it.
    task automatic sb_check(input int step);
        logic [33:0] exp;
        if (valid_m) begin
            if (sb_m.size() == 0) chk("sb_msb_unexpected", step, 32'd1, 32'd0);
            else begin
                exp = sb_m.pop_front();
                chk("sb_msb_data", step, data_m, exp[31:0]);
                chk("sb_msb_width", step, {30'd0, width_m}, {30'd0, exp[33:32]});
            end
        end
        if (valid_l) begin
            if (sb_l.size() == 0) chk("sb_lsb_unexpected", step, 32'd1, 32'd0);
            else begin
                exp = sb_l.pop_front();
                chk("sb_lsb_data", step, data_l, exp[31:0]);
                chk("sb_lsb_width", step, {30'd0, width_l}, {30'd0, exp[33:32]});
            end
        end
    endtask

    task automatic run_step(input vec_t x, input int step);
        rst = x.r; enb = x.e; validIn = x.v; dataS = x.ds; dataIn = x.din;
        if (x.ev) begin
            sb_m.push_back({x.w, x.dm});
            sb_l.push_back({x.w, x.dl});
        end
        @(posedge clk);
        #1;
        chk("valid_msb", step, {31'd0, valid_m}, {31'd0, x.ev});
        chk("valid_lsb", step, {31'd0, valid_l}, {31'd0, x.ev});
        chk("busy_msb", step, {31'd0, busy_m}, {31'd0, x.b});
        chk("busy_lsb", step, {31'd0, busy_l}, {31'd0, x.b});
        chk("data_msb", step, data_m, x.dm);
        chk("data_lsb", step, data_l, x.dl);
        chk("width_msb", step, {30'd0, width_m}, {30'd0, x.w});
        chk("width_lsb", step, {30'd0, width_l}, {30'd0, x.w});
`ifdef FROM8BIT_ERR_EN
        chk("err_msb", step, {31'd0, err_m}, {31'd0, x.er});
        chk("err_lsb", step, {31'd0, err_l}, {31'd0, x.er});
`endif
        sb_check(step);
        $display("[TB] step %0d r=%0b e=%0b v=%0b ds=%0d din=%h -> vm=%0b dm=%h vl=%0b dl=%h w=%0d b=%0b",
                 step, x.r, x.e, x.v, x.ds, x.din, valid_m, data_m, valid_l, data_l, width_m, busy_m);
    endtask

    initial begin
        rst = 1'b0; enb = 1'b0; validIn = 1'b0; dataS = 2'b00; dataIn = 8'h00;

        //   r  e  v  ds     din    ev  dm            dl            w      b  er
        // Reset held for 4 cycles (enb/validIn high must not matter).
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 2'b00, 8'h5a, 0, 32'h0,        32'h0,        2'b00, 0, 0);
        // 8-bit stream, back to back.
        add(1, 1, 1, 2'b00, 8'hff, 1, 32'h000000ff, 32'h000000ff, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 8'h00, 1, 32'h00000000, 32'h00000000, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 8'hf0, 1, 32'h000000f0, 32'h000000f0, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 8'h0f, 1, 32'h0000000f, 32'h0000000f, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 8'h9a, 1, 32'h0000009a, 32'h0000009a, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 8'h6d, 1, 32'h0000006d, 32'h0000006d, 2'b00, 0, 0);
        add(1, 1, 0, 2'b00, 8'h00, 0, 32'h0000006d, 32'h0000006d, 2'b00, 0, 0);
        // 16-bit words.
        add(1, 1, 1, 2'b01, 8'had, 0, 32'h0000006d, 32'h0000006d, 2'b00, 1, 0);
        add(1, 1, 1, 2'b01, 8'h43, 1, 32'h0000ad43, 32'h000043ad, 2'b01, 0, 0);
        add(1, 1, 1, 2'b01, 8'h54, 0, 32'h0000ad43, 32'h000043ad, 2'b01, 1, 0);
        add(1, 1, 1, 2'b01, 8'h3f, 1, 32'h0000543f, 32'h00003f54, 2'b01, 0, 0);
        // 32-bit word with a 3-cycle gap.
        add(1, 1, 1, 2'b10, 8'h95, 0, 32'h0000543f, 32'h00003f54, 2'b01, 1, 0);
        add(1, 1, 1, 2'b10, 8'hfd, 0, 32'h0000543f, 32'h00003f54, 2'b01, 1, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 2'b10, 8'h77, 0, 32'h0000543f, 32'h00003f54, 2'b01, 1, 0);
        add(1, 1, 1, 2'b10, 8'had, 0, 32'h0000543f, 32'h00003f54, 2'b01, 1, 0);
        add(1, 1, 1, 2'b10, 8'h43, 1, 32'h95fdad43, 32'h43adfd95, 2'b10, 0, 0);
        // enb hold: enb=0 with validIn=1 must be ignored.
        add(1, 1, 1, 2'b10, 8'h03, 0, 32'h95fdad43, 32'h43adfd95, 2'b10, 1, 0);
        add(1, 1, 1, 2'b10, 8'h78, 0, 32'h95fdad43, 32'h43adfd95, 2'b10, 1, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 1, 2'b10, 8'hee, 0, 32'h95fdad43, 32'h43adfd95, 2'b10, 1, 0);
        add(1, 1, 1, 2'b10, 8'hfd, 0, 32'h95fdad43, 32'h43adfd95, 2'b10, 1, 0);
        add(1, 1, 1, 2'b10, 8'hae, 1, 32'h0378fdae, 32'haefd7803, 2'b10, 0, 0);
        // Width switch mid-word: 32 -> 16.
        add(1, 1, 1, 2'b10, 8'h11, 0, 32'h0378fdae, 32'haefd7803, 2'b10, 1, 0);
        add(1, 1, 1, 2'b10, 8'h22, 0, 32'h0378fdae, 32'haefd7803, 2'b10, 1, 0);
        add(1, 1, 1, 2'b01, 8'h33, 0, 32'h0378fdae, 32'haefd7803, 2'b10, 1, 1);
        add(1, 1, 1, 2'b01, 8'h44, 1, 32'h00003344, 32'h00004433, 2'b01, 0, 0);
        // Reserved size: mid-word drops the word, idle drops just the byte.
        add(1, 1, 1, 2'b01, 8'h55, 0, 32'h00003344, 32'h00004433, 2'b01, 1, 0);
        add(1, 1, 1, 2'b11, 8'h66, 0, 32'h00003344, 32'h00004433, 2'b01, 0, 1);
        add(1, 1, 1, 2'b11, 8'h77, 0, 32'h00003344, 32'h00004433, 2'b01, 0, 0);
        // Width switch to 8-bit mid-word completes immediately.
        add(1, 1, 1, 2'b01, 8'h88, 0, 32'h00003344, 32'h00004433, 2'b01, 1, 0);
        add(1, 1, 1, 2'b00, 8'h99, 1, 32'h00000099, 32'h00000099, 2'b00, 0, 1);
        // Reset mid-word.
        add(1, 1, 1, 2'b01, 8'haa, 0, 32'h00000099, 32'h00000099, 2'b00, 1, 0);
        add(0, 1, 1, 2'b01, 8'h12, 0, 32'h0,        32'h0,        2'b00, 0, 0);
        add(1, 1, 1, 2'b01, 8'hbb, 0, 32'h0,        32'h0,        2'b00, 1, 0);
        add(1, 1, 1, 2'b01, 8'hcc, 1, 32'h0000bbcc, 32'h0000ccbb, 2'b01, 0, 0);
        add(1, 1, 0, 2'b01, 8'h00, 0, 32'h0000bbcc, 32'h0000ccbb, 2'b01, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++)
            run_step(vecs[i], i);

        // Hand-written: random 8-bit stream, one strobe per byte, no bubbles.
        for (int i = 0; i < 12; i++) begin
            vec_t x;
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            x.r = 1; x.e = 1; x.v = 1; x.ds = 2'b00; x.din = b;
            x.ev = 1; x.dm = {24'd0, b}; x.dl = {24'd0, b}; x.w = 2'b00; x.b = 0; x.er = 0;
            run_step(x, 1000 + i);
        end

        chk("sb_msb_drain", 2000, sb_m.size(), 0);
        chk("sb_lsb_drain", 2000, sb_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
